// File: rtl/ss_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ss_pkg (package)
// Purpose  : Glyph codes, 7-segment patterns and the code->segment decode
//            function used by the multiplexed seven-segment scan driver.
//            Segment vectors are {a,b,c,d,e,f,g}, active-high.
// Revision : 1.0  initial release
// ============================================================================
package ss_pkg;

   localparam logic [3:0] GLYPH_DASH  = 4'd10;
   localparam logic [3:0] GLYPH_U     = 4'd11;
   localparam logic [3:0] GLYPH_BLANK = 4'd15;

   localparam logic [6:0] SEG_0    = 7'h7E;
   localparam logic [6:0] SEG_1    = 7'h30;
   localparam logic [6:0] SEG_2    = 7'h6D;
   localparam logic [6:0] SEG_3    = 7'h79;
   localparam logic [6:0] SEG_4    = 7'h33;
   localparam logic [6:0] SEG_5    = 7'h5B;
   localparam logic [6:0] SEG_6    = 7'h5F;
   localparam logic [6:0] SEG_7    = 7'h70;
   localparam logic [6:0] SEG_8    = 7'h7F;
   localparam logic [6:0] SEG_9    = 7'h7B;
   localparam logic [6:0] SEG_DASH = 7'h01;
   localparam logic [6:0] SEG_U    = 7'h3E;
   localparam logic [6:0] SEG_OFF  = 7'h00;

   // Codes 12..15 all render dark; GLYPH_BLANK is the canonical one.
   function automatic logic [6:0] ss_decode(input logic [3:0] code);
      case (code)
         4'd0:       ss_decode = SEG_0;
         4'd1:       ss_decode = SEG_1;
         4'd2:       ss_decode = SEG_2;
         4'd3:       ss_decode = SEG_3;
         4'd4:       ss_decode = SEG_4;
         4'd5:       ss_decode = SEG_5;
         4'd6:       ss_decode = SEG_6;
         4'd7:       ss_decode = SEG_7;
         4'd8:       ss_decode = SEG_8;
         4'd9:       ss_decode = SEG_9;
         GLYPH_DASH: ss_decode = SEG_DASH;
         GLYPH_U:    ss_decode = SEG_U;
         default:    ss_decode = SEG_OFF;
      endcase
   endfunction

endpackage
`default_nettype wire

// File: rtl/ss_glyph_decode.sv
`default_nettype none
// ============================================================================
// Module   : ss_glyph_decode
// Purpose  : Combinational glyph code to 7-segment pattern (active-high).
// Ports    : code [3:0] in  - glyph code
//            seg  [6:0] out - {a,b,c,d,e,f,g}, 1 = segment on
// Revision : 1.0  initial release
// ============================================================================
module ss_glyph_decode
   import ss_pkg::*;
(
   input  logic [3:0] code,
   output logic [6:0] seg
);

   assign seg = ss_decode(code);

endmodule
`default_nettype wire

// File: rtl/ss_scan_driver.sv
`default_nettype none
// ============================================================================
// Module   : ss_scan_driver
// Purpose  : Multiplexed seven-segment driver. Scans NUM_DIGITS glyph codes,
//            one digit per SCAN_DIV-cycle slot, with DEAD_CYC all-dark cycles
//            at the start of each slot. Inputs are latched into shadow
//            registers once per frame so a frame is always coherent.
//            Optional leading-zero suppression (LZ_BLANK) and, when the
//            macro SS_DIM_EN is defined, a 4-bit PWM brightness control.
// Ports    : clk, rst (sync, active-high)
//            data_bcd [4*N-1:0] glyph codes, digit 0 rightmost
//            dp_in, blank_in [N-1:0] decimal point / force-dark per digit
//            bright [3:0] PWM level (SS_DIM_EN only)
//            an_n [N-1:0], seg_n [6:0], dp_n  active-low pins (registered)
//            frame_start  1-cycle pulse when shadows load
// Revision : 1.0  initial release
// ============================================================================
module ss_scan_driver
   import ss_pkg::*;
#(
   parameter int NUM_DIGITS = 8,
   parameter int SCAN_DIV   = 131233,
   parameter int DEAD_CYC   = 64,
   parameter int LZ_BLANK   = 0
)(
   input  logic                    clk,
   input  logic                    rst,
   input  logic [4*NUM_DIGITS-1:0] data_bcd,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   input  logic [NUM_DIGITS-1:0]   blank_in,
`ifdef SS_DIM_EN
   input  logic [3:0]              bright,
`endif
   output logic [NUM_DIGITS-1:0]   an_n,
   output logic [6:0]              seg_n,
   output logic                    dp_n,
   output logic                    frame_start
);

   localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int PRESC_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

   logic [PRESC_W-1:0]      presc;
   logic [IDX_W-1:0]        idx;
   logic                    first_cyc;
   logic [4*NUM_DIGITS-1:0] data_sh;
   logic [NUM_DIGITS-1:0]   dp_sh;
   logic [NUM_DIGITS-1:0]   blank_sh;
   logic [NUM_DIGITS-1:0]   lz_dark;
   logic                    slot_end;
   logic                    last_digit;
   logic                    load;
   logic                    pwm_ok;
   logic                    lit;
   logic [3:0]              cur_code;
   logic [6:0]              cur_seg;

   assign slot_end   = (presc == PRESC_W'(SCAN_DIV - 1));
   assign last_digit = (idx == IDX_W'(NUM_DIGITS - 1));
   // first_cyc is held high through reset so the shadows pick up fresh data
   // on the very first cycle after release.
   assign load       = first_cyc || (slot_end && last_digit);

   assign cur_code = data_sh[{idx, 2'b00} +: 4];

   ss_glyph_decode u_decode (
      .code (cur_code),
      .seg  (cur_seg)
   );

   // A digit is dark when it and every higher digit hold code 0.
   // Digit 0 is never suppressed so a zero value still shows "0".
   always_comb begin
      logic run;
      lz_dark = '0;
      run     = 1'b1;
      if (LZ_BLANK != 0) begin
         for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            run        = run && (data_sh[4*i +: 4] == 4'd0);
            lz_dark[i] = run;
         end
      end
   end

`ifdef SS_DIM_EN
   logic [3:0] pwm_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         pwm_cnt <= 4'd0;
      end else begin
         pwm_cnt <= pwm_cnt + 4'd1;
      end
   end

   assign pwm_ok = (pwm_cnt <= bright);
`else
   assign pwm_ok = 1'b1;
`endif

   assign lit = (presc >= PRESC_W'(DEAD_CYC)) && !blank_sh[idx] &&
                !lz_dark[idx] && pwm_ok;

   always_ff @(posedge clk) begin
      if (rst) begin
         presc       <= '0;
         idx         <= '0;
         first_cyc   <= 1'b1;
         data_sh     <= '0;
         dp_sh       <= '0;
         blank_sh    <= '0;
         an_n        <= '1;
         seg_n       <= 7'h7F;
         dp_n        <= 1'b1;
         frame_start <= 1'b0;
      end else begin
         first_cyc <= 1'b0;

         if (slot_end) begin
            presc <= '0;
            idx   <= last_digit ? '0 : idx + 1'b1;
         end else begin
            presc <= presc + 1'b1;
         end

         if (load) begin
            data_sh  <= data_bcd;
            dp_sh    <= dp_in;
            blank_sh <= blank_in;
         end
         frame_start <= load;

         // Anode and segments are registered together so the pins never
         // show one digit's anode with another digit's pattern.
         an_n <= '1;
         if (lit) begin
            an_n[idx] <= 1'b0;
            seg_n     <= ~cur_seg;
            dp_n      <= ~dp_sh[idx];
         end else begin
            seg_n     <= 7'h7F;
            dp_n      <= 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_ss_scan_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_ss_scan_driver
// Purpose  : Self-checking bench for ss_scan_driver with NUM_DIGITS=4,
//            SCAN_DIV=8, DEAD_CYC=2. Two instances: LZ_BLANK=0 and 1.
// Revision : 1.0  initial release
// ============================================================================
module tb_ss_scan_driver;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] data_bcd;
   logic [3:0]  dp_in;
   logic [3:0]  blank_in;
`ifdef SS_DIM_EN
   logic [3:0]  bright;
`endif
   logic [3:0]  an_n, an_n_lz;
   logic [6:0]  seg_n, seg_n_lz;
   logic        dp_n, dp_n_lz;
   logic        frame_start, frame_start_lz;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   ss_scan_driver #(.NUM_DIGITS(4), .SCAN_DIV(8), .DEAD_CYC(2), .LZ_BLANK(0)) dut (
      .clk         (clk),
      .rst         (rst),
      .data_bcd    (data_bcd),
      .dp_in       (dp_in),
      .blank_in    (blank_in),
`ifdef SS_DIM_EN
      .bright      (bright),
`endif
      .an_n        (an_n),
      .seg_n       (seg_n),
      .dp_n        (dp_n),
      .frame_start (frame_start)
   );

   ss_scan_driver #(.NUM_DIGITS(4), .SCAN_DIV(8), .DEAD_CYC(2), .LZ_BLANK(1)) dut_lz (
      .clk         (clk),
      .rst         (rst),
      .data_bcd    (data_bcd),
      .dp_in       (dp_in),
      .blank_in    (blank_in),
`ifdef SS_DIM_EN
      .bright      (bright),
`endif
      .an_n        (an_n_lz),
      .seg_n       (seg_n_lz),
      .dp_n        (dp_n_lz),
      .frame_start (frame_start_lz)
   );

   // Active-high segment table, written out by hand.
   function automatic logic [6:0] seg_tab(input logic [3:0] code);
      case (code)
         4'd0:    seg_tab = 7'h7E;
         4'd1:    seg_tab = 7'h30;
         4'd2:    seg_tab = 7'h6D;
         4'd3:    seg_tab = 7'h79;
         4'd4:    seg_tab = 7'h33;
         4'd5:    seg_tab = 7'h5B;
         4'd6:    seg_tab = 7'h5F;
         4'd7:    seg_tab = 7'h70;
         4'd8:    seg_tab = 7'h7F;
         4'd9:    seg_tab = 7'h7B;
         4'd10:   seg_tab = 7'h01;
         4'd11:   seg_tab = 7'h3E;
         default: seg_tab = 7'h00;
      endcase
   endfunction

   // Expected {an_n, seg_n, dp_n} at the k-th falling edge after reset
   // release: pins show the scan position k-1 (one cycle of latency).
   function automatic logic [11:0] model(input logic [15:0] d, input logic [3:0] dp,
                                         input logic [3:0] bl, input bit lz,
                                         input bit pwm_dark, input int k);
      int         s, dig;
      bit         on;
      logic [3:0] code;
      logic [3:0] an;
      s    = k - 1;
      dig  = (s / 8) % 4;
      on   = ((s % 8) >= 2) && !bl[dig] && !pwm_dark;
      if (lz && dig > 0) begin
         bit allz;
         allz = 1'b1;
         for (int j = dig; j < 4; j++)
            if (d[4*j +: 4] != 4'd0) allz = 1'b0;
         if (allz) on = 1'b0;
      end
      code = d[4*dig +: 4];
      an   = 4'hF;
      if (on) begin
         an[dig] = 1'b0;
         model   = {an, ~seg_tab(code), ~dp[dig]};
      end else begin
         model   = {an, 7'h7F, 1'b1};
      end
   endfunction

   task automatic do_reset;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset;
      int pulses;
      data_bcd = 16'h1234; dp_in = 4'h0; blank_in = 4'h0;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({an_n, seg_n, dp_n, frame_start} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL reset_pins: got an=%h seg=%h dp=%b fs=%b, want F 7f 1 0",
                  an_n, seg_n, dp_n, frame_start);
      end
      rst = 1'b0;
      pulses = 0;
      for (int k = 1; k <= 31; k++) begin
         @(negedge clk);
         if (frame_start === 1'b1) pulses++;
         if (k == 1) begin
            checks++;
            if (frame_start !== 1'b1) begin
               errors++;
               $display("FAIL reset_first_fs: got %b want 1", frame_start);
            end
         end
      end
      checks++;
      if (pulses != 1) begin
         errors++;
         $display("FAIL reset_fs_once: got %0d pulses want 1", pulses);
      end
   endtask

   task automatic test_scan;
      logic [11:0] exp;
      data_bcd = 16'h1234; dp_in = 4'h0; blank_in = 4'h0;
      do_reset();
      for (int k = 1; k <= 64; k++) begin
         @(negedge clk);
         exp = model(16'h1234, 4'h0, 4'h0, 1'b0, 1'b0, k);
         checks++;
         if ({an_n, seg_n, dp_n} !== exp) begin
            errors++;
            $display("FAIL scan k=%0d: got %h want %h", k, {an_n, seg_n, dp_n}, exp);
         end
         if (k == 3) begin
            checks++;
            if (an_n !== 4'hE || seg_n !== 7'h4C) begin
               errors++;
               $display("FAIL scan_digit0: got an=%h seg=%h want E 4c", an_n, seg_n);
            end
         end
         if (k == 32 || k == 64) begin
            checks++;
            if (frame_start !== 1'b1) begin
               errors++;
               $display("FAIL scan_period k=%0d: got fs=%b want 1", k, frame_start);
            end
         end
      end
   endtask

   task automatic test_coherence;
      logic [11:0] exp;
      data_bcd = 16'h1234; dp_in = 4'h0; blank_in = 4'h0;
      do_reset();
      for (int k = 1; k <= 72; k++) begin
         @(negedge clk);
         exp = model((k <= 32) ? 16'h1234 : 16'h9999, 4'h0, 4'h0, 1'b0, 1'b0, k);
         checks++;
         if ({an_n, seg_n, dp_n} !== exp) begin
            errors++;
            $display("FAIL coherence k=%0d: got %h want %h", k, {an_n, seg_n, dp_n}, exp);
         end
         if (k == 12) data_bcd = 16'h9999;
      end
   endtask

   task automatic test_glyphs;
      logic [11:0] exp;
      data_bcd = 16'hAB0F; dp_in = 4'b0010; blank_in = 4'b0100;
      do_reset();
      for (int k = 1; k <= 32; k++) begin
         @(negedge clk);
         exp = model(16'hAB0F, 4'b0010, 4'b0100, 1'b0, 1'b0, k);
         checks++;
         if ({an_n, seg_n, dp_n} !== exp) begin
            errors++;
            $display("FAIL glyphs k=%0d: got %h want %h", k, {an_n, seg_n, dp_n}, exp);
         end
         if (k == 11) begin
            checks++;
            if ({an_n, seg_n, dp_n} !== {4'hD, 7'h01, 1'b0}) begin
               errors++;
               $display("FAIL glyph_d1_dp: got %h want %h", {an_n, seg_n, dp_n}, {4'hD, 7'h01, 1'b0});
            end
         end
         if (k == 27) begin
            checks++;
            if ({an_n, seg_n} !== {4'h7, 7'h7E}) begin
               errors++;
               $display("FAIL glyph_d3_dash: got %h want %h", {an_n, seg_n}, {4'h7, 7'h7E});
            end
         end
      end
   endtask

   task automatic test_lz;
      logic [11:0] exp;
      data_bcd = 16'h0050; dp_in = 4'h0; blank_in = 4'h0;
      do_reset();
      for (int k = 1; k <= 32; k++) begin
         @(negedge clk);
         exp = model(16'h0050, 4'h0, 4'h0, 1'b1, 1'b0, k);
         checks++;
         if ({an_n_lz, seg_n_lz, dp_n_lz} !== exp) begin
            errors++;
            $display("FAIL lz_0050 k=%0d: got %h want %h", k, {an_n_lz, seg_n_lz, dp_n_lz}, exp);
         end
         if (k == 11) begin
            checks++;
            if ({an_n_lz, seg_n_lz} !== {4'hD, 7'h24}) begin
               errors++;
               $display("FAIL lz_d1_five: got %h want %h", {an_n_lz, seg_n_lz}, {4'hD, 7'h24});
            end
         end
      end
      data_bcd = 16'h0000;
      do_reset();
      for (int k = 1; k <= 32; k++) begin
         @(negedge clk);
         exp = model(16'h0000, 4'h0, 4'h0, 1'b1, 1'b0, k);
         checks++;
         if ({an_n_lz, seg_n_lz, dp_n_lz} !== exp) begin
            errors++;
            $display("FAIL lz_zero k=%0d: got %h want %h", k, {an_n_lz, seg_n_lz, dp_n_lz}, exp);
         end
         if (k == 27) begin
            checks++;
            if ({an_n, seg_n} !== {4'h7, 7'h01}) begin
               errors++;
               $display("FAIL nolz_d3_zero: got %h want %h", {an_n, seg_n}, {4'h7, 7'h01});
            end
         end
      end
   endtask

`ifdef SS_DIM_EN
   task automatic test_dim;
      logic [11:0] exp;
      bright = 4'd3;
      data_bcd = 16'h1234; dp_in = 4'h0; blank_in = 4'h0;
      do_reset();
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         exp = model(16'h1234, 4'h0, 4'h0, 1'b0, (((k - 1) % 16) > 3), k);
         checks++;
         if ({an_n, seg_n, dp_n} !== exp) begin
            errors++;
            $display("FAIL dim k=%0d: got %h want %h", k, {an_n, seg_n, dp_n}, exp);
         end
      end
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if ({an_n, seg_n, dp_n} !== {4'hF, 7'h7F, 1'b1}) begin
         errors++;
         $display("FAIL dim_midrst: got %h want fff", {an_n, seg_n, dp_n});
      end
      rst = 1'b0;
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         exp = model(16'h1234, 4'h0, 4'h0, 1'b0, (((k - 1) % 16) > 3), k);
         checks++;
         if ({an_n, seg_n, dp_n} !== exp) begin
            errors++;
            $display("FAIL dim_restart k=%0d: got %h want %h", k, {an_n, seg_n, dp_n}, exp);
         end
      end
      bright = 4'd15;
   endtask
`endif

   initial begin
      rst = 1'b1; data_bcd = '0; dp_in = '0; blank_in = '0;
`ifdef SS_DIM_EN
      bright = 4'd15;
`endif
      test_reset();
      test_scan();
      test_coherence();
      test_glyphs();
      test_lz();
`ifdef SS_DIM_EN
      test_dim();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
